// File: rtl/cv32e40p_pkg2_ft.sv
// Shared types for the fault-tolerance supervisor: command opcodes, health states,
// default counter width and a replica popcount helper.
package cv32e40p_pkg2_ft;

  localparam int FT_CNT_W  = 16;
  localparam int FT_N_REPL = 3;

  typedef enum logic [1:0] {
    OP_READ_DET   = 2'd0,
    OP_READ_COR   = 2'd1,
    OP_SET_BROKEN = 2'd2,
    OP_CLEAR      = 2'd3
  } ft_op_e;

  typedef enum logic [1:0] {
    HEALTH_OK       = 2'd0,
    HEALTH_DEGRADED = 2'd1,
    HEALTH_FAILED   = 2'd2
  } ft_health_e;

  function automatic logic [1:0] broken_count(input logic [FT_N_REPL-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Saturating event accumulator: adds the popcount of i_inc each cycle and never wraps.
// i_clear restarts the count from zero while still adding the current increments.
module cv32e40p_ft_sat_counter import cv32e40p_pkg2_ft::*; #(
  parameter int N_IN  = 4,
  parameter int CNT_W = FT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [N_IN-1:0]  i_inc,
  output logic [CNT_W-1:0] o_count
);

  // Six guard bits cover a popcount of up to 16 inputs on top of a saturated count.
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] MAX_VAL = {6'd0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] w_pop;
  logic [SUM_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_pop = w_pop + SUM_W'(i_inc[i]);
    end
    w_base = i_clear ? '0 : {6'd0, r_count};
    w_sum  = w_base + w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_sum > MAX_VAL) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cv32e40p_ft_supervisor.sv
// Fault-tolerance supervisor: error counters, command port, force-broken pulses and health FSM.
// Optional health interrupt irq_o is built only when CV32E40P_FT_SUP_IRQ_EN is defined.
module cv32e40p_ft_supervisor import cv32e40p_pkg2_ft::*; #(
  parameter int N_MOD = 4,
  parameter int CNT_W = FT_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MOD-1:0]              err_detected_i,
  input  logic [N_MOD-1:0]              err_corrected_i,
  input  logic [N_MOD-1:0][FT_N_REPL-1:0] is_broken_i,
  output logic [N_MOD-1:0][FT_N_REPL-1:0] set_broken_o,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [1:0]                    cmd_op_i,
  input  logic [3:0]                    cmd_mod_i,
  input  logic [1:0]                    cmd_blk_i,
  output logic                          rsp_valid_o,
  output logic [CNT_W-1:0]              rsp_data_o,
  output logic [1:0]                    health_o
`ifdef CV32E40P_FT_SUP_IRQ_EN
  ,
  output logic                          irq_o
`endif
);

  logic                          r_rsp_valid;
  logic [CNT_W-1:0]              r_rsp_data;
  logic [N_MOD-1:0][FT_N_REPL-1:0] r_set_broken;
  ft_health_e                    r_health;

  ft_op_e           w_op;
  logic             w_accept;
  logic             w_clear;
  logic             w_set_ok;
  logic [CNT_W-1:0] w_det_cnt;
  logic [CNT_W-1:0] w_cor_cnt;
  logic [CNT_W-1:0] w_rsp_data;
  logic             w_any_one;
  logic             w_any_two;

  // The port stalls only during the response cycle, so a single response is ever in flight.
  assign w_op     = ft_op_e'(cmd_op_i);
  assign w_accept = cmd_valid_i & ~r_rsp_valid;
  assign w_clear  = w_accept && (w_op == OP_CLEAR);
  assign w_set_ok = w_accept && (w_op == OP_SET_BROKEN) && (cmd_blk_i != 2'd3) &&
                    (int'({28'd0, cmd_mod_i}) < N_MOD);

  cv32e40p_ft_sat_counter #(.N_IN(N_MOD), .CNT_W(CNT_W)) u_det_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_inc   (err_detected_i),
    .o_count (w_det_cnt)
  );

  cv32e40p_ft_sat_counter #(.N_IN(N_MOD), .CNT_W(CNT_W)) u_cor_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_inc   (err_corrected_i),
    .o_count (w_cor_cnt)
  );

  always_comb begin
    w_rsp_data = '0;
    case (w_op)
      OP_READ_DET:   w_rsp_data = w_det_cnt;
      OP_READ_COR:   w_rsp_data = w_cor_cnt;
      OP_SET_BROKEN: w_rsp_data = CNT_W'(w_set_ok);
      default:       w_rsp_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_set_broken <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_data  <= w_accept ? w_rsp_data : '0;
      for (int m = 0; m < N_MOD; m++) begin
        for (int b = 0; b < FT_N_REPL; b++) begin
          r_set_broken[m][b] <= w_set_ok && (cmd_mod_i == 4'(m)) && (cmd_blk_i == 2'(b));
        end
      end
    end
  end

  always_comb begin
    w_any_one = 1'b0;
    w_any_two = 1'b0;
    for (int m = 0; m < N_MOD; m++) begin
      if (broken_count(is_broken_i[m]) >= 2'd2) w_any_two = 1'b1;
      if (broken_count(is_broken_i[m]) == 2'd1) w_any_one = 1'b1;
    end
  end

  // A module with two broken replicas has lost its majority vote, so FAILED is final until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_health <= HEALTH_OK;
    end else begin
      case (r_health)
        HEALTH_OK: begin
          if (w_any_two)      r_health <= HEALTH_FAILED;
          else if (w_any_one) r_health <= HEALTH_DEGRADED;
        end
        HEALTH_DEGRADED: begin
          if (w_any_two)       r_health <= HEALTH_FAILED;
          else if (!w_any_one) r_health <= HEALTH_OK;
        end
        HEALTH_FAILED: r_health <= HEALTH_FAILED;
        default:       r_health <= HEALTH_FAILED;
      endcase
    end
  end

`ifdef CV32E40P_FT_SUP_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if ((r_health == HEALTH_OK) && (w_any_one || w_any_two)) begin
      r_irq <= 1'b1;
    end else if (w_clear) begin
      r_irq <= 1'b0;
    end
  end

  assign irq_o = r_irq;
`endif

  assign cmd_ready_o  = ~r_rsp_valid;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign set_broken_o = r_set_broken;
  assign health_o     = r_health;

endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
// Self-checking bench for cv32e40p_ft_supervisor (N_MOD=4, CNT_W=4); a behavioural model
// feeds a response scoreboard, plus directed vectors for the corner cases.
module tb_cv32e40p_ft_supervisor;

  localparam int N_MOD = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic             clk;
  logic             rst;
  logic [3:0]       errDet;
  logic [3:0]       errCor;
  logic [3:0][2:0]  isBroken;
  logic [3:0][2:0]  setBroken;
  logic             cmdValid;
  logic             cmdReady;
  logic [1:0]       cmdOp;
  logic [3:0]       cmdMod;
  logic [1:0]       cmdBlk;
  logic             rspValid;
  logic [3:0]       rspData;
  logic [1:0]       health;
`ifdef CV32E40P_FT_SUP_IRQ_EN
  logic             irq;
`endif

  cv32e40p_ft_supervisor #(.N_MOD(N_MOD), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .err_detected_i  (errDet),
    .err_corrected_i (errCor),
    .is_broken_i     (isBroken),
    .set_broken_o    (setBroken),
    .cmd_valid_i     (cmdValid),
    .cmd_ready_o     (cmdReady),
    .cmd_op_i        (cmdOp),
    .cmd_mod_i       (cmdMod),
    .cmd_blk_i       (cmdBlk),
    .rsp_valid_o     (rspValid),
    .rsp_data_o      (rspData),
    .health_o        (health)
`ifdef CV32E40P_FT_SUP_IRQ_EN
    ,
    .irq_o           (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int data;
    int pulse;
  } rsp_t;

  typedef struct {
    logic [3:0] mod;
    logic [1:0] blk;
    int         expData;
    int         expPulse;
  } vec_t;

  rsp_t sbQ[$];
  vec_t vecs[6];

  int checkCount = 0;
  int errCount   = 0;

  int mDet;
  int mCor;
  int mHealth;
  int mIrq;
  bit mPending;

  task automatic checkEq(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popc4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  function automatic int satAdd(input int a, input int b);
    return (a + b > MAXC) ? MAXC : a + b;
  endfunction

  task automatic modelReset();
    mDet     = 0;
    mCor     = 0;
    mHealth  = 0;
    mIrq     = 0;
    mPending = 0;
    sbQ.delete();
  endtask

  task automatic checkOutput();
    rsp_t r;
    if (mPending) begin
      if (sbQ.size() == 0) begin
        checkEq("scoreboard_empty", 1, 0);
      end else begin
        r = sbQ.pop_front();
        checkEq("rsp_valid", int'(rspValid), 1);
        checkEq("rsp_data", int'(rspData), r.data);
        checkEq("set_broken", int'(setBroken), r.pulse);
        checkEq("cmd_ready_busy", int'(cmdReady), 0);
      end
    end else begin
      checkEq("rsp_valid_idle", int'(rspValid), 0);
      checkEq("rsp_data_idle", int'(rspData), 0);
      checkEq("set_broken_idle", int'(setBroken), 0);
      checkEq("cmd_ready_idle", int'(cmdReady), 1);
    end
    checkEq("health", int'(health), mHealth);
`ifdef CV32E40P_FT_SUP_IRQ_EN
    checkEq("irq", int'(irq), mIrq);
`endif
  endtask

  // Advances the model over one rising edge using the inputs currently driven, then checks the DUT.
  task automatic tick();
    bit   acc;
    rsp_t r;
    int   nOne;
    int   nTwo;
    int   c;
    acc = cmdValid && !mPending;
    if (acc) begin
      r.data  = 0;
      r.pulse = 0;
      case (cmdOp)
        2'd0: r.data = mDet;
        2'd1: r.data = mCor;
        2'd2: if (cmdBlk != 2'd3 && int'(cmdMod) < N_MOD) begin
          r.data  = 1;
          r.pulse = 1 << (int'(cmdMod) * 3 + int'(cmdBlk));
        end
        default: r.data = 0;
      endcase
      sbQ.push_back(r);
    end
    if (acc && cmdOp == 2'd3) begin
      mDet = satAdd(0, popc4(errDet));
      mCor = satAdd(0, popc4(errCor));
    end else begin
      mDet = satAdd(mDet, popc4(errDet));
      mCor = satAdd(mCor, popc4(errCor));
    end
    nOne = 0;
    nTwo = 0;
    for (int m = 0; m < N_MOD; m++) begin
      c = int'(isBroken[m][0]) + int'(isBroken[m][1]) + int'(isBroken[m][2]);
      if (c == 1) nOne++;
      if (c >= 2) nTwo++;
    end
    if (mHealth == 0 && (nOne + nTwo) > 0) mIrq = 1;
    else if (acc && cmdOp == 2'd3) mIrq = 0;
    if (mHealth != 2) begin
      if (nTwo > 0)      mHealth = 2;
      else if (nOne > 0) mHealth = 1;
      else               mHealth = 0;
    end
    mPending = acc;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] mod, input logic [1:0] blk);
    if (mPending) tick();
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdMod   = mod;
    cmdBlk   = blk;
    tick();
    cmdValid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    errDet   = '0;
    errCor   = '0;
    isBroken = '0;
    cmdValid = 1'b0;
    cmdOp    = '0;
    cmdMod   = '0;
    cmdBlk   = '0;
    modelReset();

    vecs[0] = '{mod: 4'd2,  blk: 2'd1, expData: 1, expPulse: 128};
    vecs[1] = '{mod: 4'd0,  blk: 2'd0, expData: 1, expPulse: 1};
    vecs[2] = '{mod: 4'd3,  blk: 2'd2, expData: 1, expPulse: 2048};
    vecs[3] = '{mod: 4'd2,  blk: 2'd3, expData: 0, expPulse: 0};
    vecs[4] = '{mod: 4'd5,  blk: 2'd0, expData: 0, expPulse: 0};
    vecs[5] = '{mod: 4'd15, blk: 2'd2, expData: 0, expPulse: 0};

    #2;
    checkOutput();
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Saturation of the detected counter
    errDet = 4'b1111;
    repeat (5) tick();
    errDet = 4'b0000;
    applyStimulus(2'd0, 4'd0, 2'd0);
    checkEq("sat_read_det", int'(rspData), 15);
    applyStimulus(2'd1, 4'd0, 2'd0);
    checkEq("sat_read_cor", int'(rspData), 0);

    // Force-broken vectors, valid and invalid targets
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd2, vecs[i].mod, vecs[i].blk);
      checkEq("vec_data", int'(rspData), vecs[i].expData);
      checkEq("vec_pulse", int'(setBroken), vecs[i].expPulse);
      tick();
      checkEq("vec_pulse_gone", int'(setBroken), 0);
    end

    // Degraded and back to OK
    isBroken[1] = 3'b100;
    tick();
    checkEq("health_deg_m1", int'(health), 1);
    isBroken = '0;
    tick();
    checkEq("health_back_ok", int'(health), 0);

    // Degraded, failed, then sticky failed
    isBroken[0] = 3'b001;
    tick();
    checkEq("health_deg", int'(health), 1);
    isBroken[0] = 3'b011;
    tick();
    checkEq("health_failed", int'(health), 2);
    isBroken = '0;
    repeat (2) tick();
    checkEq("health_sticky", int'(health), 2);

    // CLEAR while corrected errors arrive; commands still accepted in FAILED
    errCor = 4'b0011;
    applyStimulus(2'd3, 4'd0, 2'd0);
    checkEq("clear_rsp", int'(rspData), 0);
    errCor = 4'b0000;
`ifdef CV32E40P_FT_SUP_IRQ_EN
    checkEq("irq_cleared", int'(irq), 0);
`endif
    applyStimulus(2'd1, 4'd0, 2'd0);
    checkEq("clear_read_cor", int'(rspData), 2);
    applyStimulus(2'd0, 4'd0, 2'd0);
    checkEq("clear_read_det", int'(rspData), 0);

    // Reset in the acceptance cycle
    if (mPending) tick();
    cmdValid = 1'b1;
    cmdOp    = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    checkOutput();
    #2;
    rst = 1'b0;
    applyStimulus(2'd2, 4'd1, 2'd0);
    checkEq("first_cmd_after_rst", int'(rspValid), 1);
    checkEq("first_cmd_pulse", int'(setBroken), 8);

    // Reset cancels a response and pulse already on the outputs
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Random traffic with back-to-back command attempts
    for (int i = 0; i < 60; i++) begin
      errDet   = 4'($urandom_range(0, 15));
      errCor   = 4'($urandom_range(0, 15));
      cmdValid = 1'($urandom_range(0, 1));
      cmdOp    = 2'($urandom_range(0, 3));
      cmdMod   = 4'($urandom_range(0, 5));
      cmdBlk   = 2'($urandom_range(0, 3));
      tick();
    end
    cmdValid = 1'b0;
    errDet   = '0;
    errCor   = '0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
